// File: rtl/dram_lsu.sv
// Load/store unit bridging the RV32 memory stage to a word-addressed DRAM with
// asynchronous read and synchronous write; sub-word stores use read-modify-write.
module dram_lsu #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] dram_a,
    output logic              dram_we,
    output logic [31:0]       dram_din,
    input  logic [31:0]       dram_spo
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] RMW_WR = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       old_q, old_d;
    logic [1:0]        off_q, off_d;
    logic              half_q, half_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic        accept, err, sub_store, word_store;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext, merged;
    logic        unused_addr;

    assign unused_addr = ^req_addr[31:ADDR_W+2];
    assign req_ready   = (state_q == IDLE);
    assign accept      = req_valid && req_ready;

    // Illegal funct3 (including unsigned store encodings) or misalignment.
    always_comb begin
        err = 1'b0;
        case (req_funct3)
            3'b000, 3'b100: err = 1'b0;
            3'b001, 3'b101: err = req_addr[0];
            3'b010:         err = (req_addr[1:0] != 2'b00);
            default:        err = 1'b1;
        endcase
        if (req_we && req_funct3[2]) err = 1'b1;
    end

    assign sub_store  = accept && req_we && !err && (req_funct3[1:0] != 2'b10);
    assign word_store = accept && req_we && !err && (req_funct3[1:0] == 2'b10);

    assign ld_byte = dram_spo[{req_addr[1:0], 3'b000} +: 8];
    assign ld_half = req_addr[1] ? dram_spo[31:16] : dram_spo[15:0];

    always_comb begin
        case (req_funct3)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = dram_spo;
        endcase
    end

    always_comb begin
        merged = old_q;
        if (half_q) begin
            if (off_q[1]) merged[31:16] = wdata_q;
            else          merged[15:0]  = wdata_q;
        end else begin
            merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    assign dram_a   = (state_q == RMW_WR) ? addr_q : req_addr[ADDR_W+1:2];
    assign dram_din = (state_q == RMW_WR) ? merged : req_wdata;
    assign dram_we  = rst_n && ((state_q == RMW_WR) || word_store);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        old_d       = old_q;
        off_d       = off_q;
        half_d      = half_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'h0;
        rsp_err_d   = 1'b0;
        if (state_q == RMW_WR) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
        end else if (accept) begin
            if (sub_store) begin
                state_d = RMW_WR;
                addr_d  = req_addr[ADDR_W+1:2];
                old_d   = dram_spo;
                off_d   = req_addr[1:0];
                half_d  = req_funct3[0];
                wdata_d = req_wdata[15:0];
            end else begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = err;
                if (!req_we && !err) rsp_rdata_d = ld_ext;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            old_q       <= 32'h0;
            off_q       <= 2'b00;
            half_q      <= 1'b0;
            wdata_q     <= 16'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            old_q       <= old_d;
            off_q       <= off_d;
            half_q      <= half_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dram_lsu.sv
// Bench for dram_lsu: behavioural DRAM plus an arithmetic reference model of
// RV32 load/store semantics; directed cases then randomized transactions.
module tb_dram_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] dram_a;
    logic        dram_we;
    logic [31:0] dram_din;
    logic [31:0] dram_spo;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;

    logic [31:0] dram [0:65535];
    logic [31:0] refm [0:65535];

    always #5 clk = ~clk;

    dram_lsu #(.ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .dram_a(dram_a), .dram_we(dram_we), .dram_din(dram_din), .dram_spo(dram_spo)
    );

    // Read data is undefined while the write enable is high.
    assign dram_spo = (dram_we === 1'b1) ? 32'hxxxxxxxx : dram[dram_a];

    always @(posedge clk) begin
        if (dram_we === 1'b1) begin
            dram[dram_a] <= dram_din;
            we_cnt <= we_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: expected response, latency and DRAM write count; updates refm.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic e, output logic [31:0] rd,
                         output int lat, output int nw);
        int unsigned idx, off, w, v, mask;
        idx = (a / 4) % 65536;
        off = a % 4;
        w   = refm[idx];
        e   = (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && f3 >= 4) ||
              ((f3 == 1 || f3 == 5) && (off % 2 != 0)) || (f3 == 2 && off != 0);
        rd = 0; lat = 1; nw = 0;
        if (e) return;
        if (!we) begin
            if (f3 == 0 || f3 == 4) begin
                v = (w >> (8 * off)) & 255;
                if (f3 == 0 && v >= 128) v = v + 32'hFFFFFF00;
            end else if (f3 == 1 || f3 == 5) begin
                v = (w >> (8 * off)) & 65535;
                if (f3 == 1 && v >= 32768) v = v + 32'hFFFF0000;
            end else begin
                v = w;
            end
            rd = v;
        end else begin
            nw = 1;
            if (f3 == 2) begin
                w = wd;
            end else begin
                mask = (f3 == 0) ? 255 : 65535;
                w = (w & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
                lat = 2;
            end
            refm[idx] = w;
        end
    endtask

    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input string tag);
        logic e;
        logic [31:0] rd;
        int lat_e, nw_e, base, lat, idx;
        logic rdy1;
        model(we, f3, a, wd, e, rd, lat_e, nw_e);
        idx = int'((a / 4) % 65536);
        @(negedge clk);
        check({tag, " ready_before"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        base = we_cnt;
        @(negedge clk);
        req_valid = 1'b0;
        rdy1 = req_ready;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 5) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
        check({tag, " latency"}, lat, lat_e);
        check({tag, " rdata"}, rsp_rdata, rd);
        check({tag, " err"}, {31'b0, rsp_err}, {31'b0, e});
        check({tag, " ready_after_accept"}, {31'b0, rdy1}, (lat_e == 1) ? 32'd1 : 32'd0);
        check({tag, " writes"}, we_cnt - base, nw_e);
        check({tag, " mem_word"}, dram[idx], refm[idx]);
        @(negedge clk);
        check({tag, " pulse_end"}, {31'b0, rsp_valid}, 32'd0);
    endtask

    initial begin
        logic e;
        logic [31:0] r0, r1, r2, r3;
        int l, n, base;

        for (int i = 0; i < 65536; i++) begin
            dram[i] = i * 32'h9E3779B9;
            refm[i] = i * 32'h9E3779B9;
        end

        #2;
        check("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst rsp_rdata", rsp_rdata, 32'd0);
        check("rst rsp_err", {31'b0, rsp_err}, 32'd0);
        check("rst req_ready", {31'b0, req_ready}, 32'd1);
        check("rst dram_we", {31'b0, dram_we}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        xact(1, 3'b010, 32'h10, 32'hDEADBEEF, "sw10");
        xact(0, 3'b010, 32'h10, 32'h0, "lw10");
        check("lw10 value", rsp_rdata, 32'h0);
        xact(0, 3'b000, 32'h13, 32'h0, "lb13");
        xact(0, 3'b100, 32'h13, 32'h0, "lbu13");
        xact(0, 3'b001, 32'h12, 32'h0, "lh12");
        xact(0, 3'b101, 32'h12, 32'h0, "lhu12");
        check("ref word4 init", refm[4], 32'hDEADBEEF);
        xact(1, 3'b000, 32'h11, 32'h000000A5, "sb11");
        check("ref sb11", refm[4], 32'hDEADA5EF);
        xact(1, 3'b001, 32'h12, 32'h00001234, "sh12");
        check("ref sh12", refm[4], 32'h1234A5EF);
        xact(0, 3'b010, 32'h02, 32'h0, "lw02_mis");
        xact(1, 3'b001, 32'h03, 32'h5555, "sh03_mis");
        xact(0, 3'b011, 32'h00, 32'h0, "f3_011");
        xact(1, 3'b100, 32'h04, 32'h77, "sbu_illegal");
        xact(0, 3'b111, 32'h08, 32'h0, "f3_111");

        // Back-to-back with req_valid held: LW 0, LW 4, SW 8, LW 8.
        base = we_cnt;
        model(0, 3'b010, 32'h0, 32'h0, e, r0, l, n);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0;
        model(0, 3'b010, 32'h4, 32'h0, e, r1, l, n);
        @(negedge clk);
        check("b2b0 valid", {31'b0, rsp_valid}, 32'd1);
        check("b2b0 rdata", rsp_rdata, r0);
        check("b2b1 ready", {31'b0, req_ready}, 32'd1);
        req_addr = 32'h4;
        model(1, 3'b010, 32'h8, 32'hCAFEF00D, e, r2, l, n);
        @(negedge clk);
        check("b2b1 valid", {31'b0, rsp_valid}, 32'd1);
        check("b2b1 rdata", rsp_rdata, r1);
        req_we = 1'b1; req_addr = 32'h8; req_wdata = 32'hCAFEF00D;
        model(0, 3'b010, 32'h8, 32'h0, e, r3, l, n);
        @(negedge clk);
        check("b2b2 valid", {31'b0, rsp_valid}, 32'd1);
        check("b2b2 rdata", rsp_rdata, r2);
        req_we = 1'b0;
        @(negedge clk);
        check("b2b3 valid", {31'b0, rsp_valid}, 32'd1);
        check("b2b3 store_to_load", rsp_rdata, r3);
        check("b2b3 value", r3, 32'hCAFEF00D);
        req_valid = 1'b0;
        @(negedge clk);
        check("b2b end", {31'b0, rsp_valid}, 32'd0);
        check("b2b writes", we_cnt - base, 32'd1);

        // Reset during RMW_WR of SB 0x20.
        base = we_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h20; req_wdata = 32'h5A;
        @(negedge clk);
        req_valid = 1'b0;
        check("rmw we", {31'b0, dram_we}, 32'd1);
        check("rmw ready", {31'b0, req_ready}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("rst_rmw we", {31'b0, dram_we}, 32'd0);
        check("rst_rmw ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        check("rst_rmw no_rsp", {31'b0, rsp_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rmw no_rsp2", {31'b0, rsp_valid}, 32'd0);
        check("rst_rmw ready_rel", {31'b0, req_ready}, 32'd1);
        check("rst_rmw word8", dram[8], refm[8]);
        check("rst_rmw writes", we_cnt - base, 32'd0);

        for (int k = 0; k < 250; k++) begin
            logic [31:0] a;
            a = {$urandom_range(0, 16383), 18'h0} | $urandom_range(0, 63);
            xact(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dram_lsu.md
Name: dram_lsu

Overview:
- Load/store unit between the core's memory stage and the word-addressed data DRAM.
- The DRAM reads asynchronously, writes synchronously, and its read data is undefined while its write enable is high.
- This block turns RV32 byte, halfword and word accesses into legal DRAM cycles. It uses read-modify-write for sub-word stores, sign/zero-extends loads and flags misaligned or illegal accesses.
- Responses are registered, one per accepted request.

Parameters:
ADDR_W, 16, DRAM word-address width; byte address bits [ADDR_W+1:2] select the word, higher bits ignored

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid && req_ready
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  32  byte address
req_wdata  input  32  store data, LSB-aligned (byte in [7:0], half in [15:0])
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  32  extended load data; 0 for stores and errors
rsp_err  output  1  misaligned/illegal access, valid with rsp_valid
dram_a  output  ADDR_W  DRAM word address
dram_we  output  1  DRAM write enable
dram_din  output  32  DRAM write data
dram_spo  input  32  DRAM asynchronous read data

Behaviour:
- States: IDLE, RMW_WR. req_ready = (state == IDLE).
- Reset values (asserted asynchronously): state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0. dram_we is forced 0 while rst_n is low.
- dram_a: req_addr[ADDR_W+1:2] in IDLE; latched word address in RMW_WR.
- Error classes, checked at accept:
  - H/HU/SH with addr[0] != 0.
  - W/SW with addr[1:0] != 0.
  - funct3 in {011, 110, 111}, or any store funct3 other than 000/001/010.
  - Result: no DRAM write; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0.
- Load accepted in IDLE:
  - Same cycle: sample dram_spo (dram_we=0), select the byte/half by addr[1:0], extend, register into rsp_rdata.
  - Next cycle: rsp_valid=1. Latency 1.
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- SW accepted in IDLE: same cycle dram_we=1, dram_din=req_wdata. Next cycle rsp_valid=1. Latency 1.
- SB/SH accepted in IDLE:
  - Accept cycle: dram_we=0; latch dram_spo, address, offset, size and wdata. Go to RMW_WR.
  - RMW_WR: dram_we=1, dram_din = old word with the target byte/half replaced (lane = addr[1:0] for B, addr[1] for H). Return to IDLE.
  - rsp_valid the cycle after RMW_WR. Latency 2; req_ready=0 during RMW_WR.
- dram_spo is never sampled in a cycle where dram_we=1.
- rsp_valid is a registered single-cycle pulse. IDLE may accept a new request in the same cycle rsp_valid is high, giving 1/cycle throughput for loads and SW.
- Load immediately after a store to the same word: the store was written on the previous edge, so the load returns the new data.
- No backpressure on rsp; the consumer must take it.
- req inputs are ignored when req_ready=0.
- Reset in RMW_WR: state returns to IDLE at once and dram_we drops. The RMW write is lost and no response is issued.
- Address bits above ADDR_W+1 are not checked.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> dram_we one cycle at word 4; load rsp_valid 1 cycle after accept, rsp_rdata 0xDEADBEEF, rsp_err 0.
- LB 0x13, LBU 0x13, LH 0x12, LHU 0x12 on word 0xDEADBEEF -> rsp_rdata 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD, 0x0000DEAD.
- SB 0x11 data 0x000000A5 on word 0xDEADBEEF -> req_ready low 1 cycle, single write 0xDEADA5EF in RMW_WR, rsp_valid 2 cycles after accept; then SH 0x12 data 0x1234 -> word 0x1234A5EF.
- LW 0x02, SH 0x03, funct3 011 -> rsp_err=1, rsp_rdata=0, dram_we never asserted.
- Back-to-back LW 0x0, LW 0x4, SW 0x8 with req_valid held -> accepted on consecutive cycles, three consecutive rsp_valid pulses.
- rst_n low during RMW_WR of SB 0x20 -> dram_we drops immediately, word 8 unchanged, no rsp_valid; req_ready=1 after release.
